sram_banked_1rw_ctrl: RTL and testbench
=======================================

# sram_banked_1rw_ctrl

Parametrised front end for banks of 1rw OpenRAM macros. Gives a single valid/ready request channel and a backpressured response channel over `N_BANKS` macros of `2**BANK_ADDR_WIDTH` words each. It adds three things the bare macro lacks: bank decoding, a 2-entry response buffer so the consumer may stall, and an optional zero-initialisation sweep. It sits between the core datapath and the macro instances.

## Interface
- `DATA_WIDTH`, 150, word width (also the macro width).
- `BANK_ADDR_WIDTH`, 9, address width of one macro (512 words).
- `ADDR_WIDTH`, 10, total word address width. Must be ≥ `BANK_ADDR_WIDTH`.
- `N_BANKS`, derived, equals `2**(ADDR_WIDTH-BANK_ADDR_WIDTH)`. Upper address bits select the bank.
---
- `clk0` in 1: single clock; also clocks all macros.
- `rstb0` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_WIDTH`: word address.
- `req_wdata` in `DATA_WIDTH`: write data.
- `rsp_valid` out 1: read data present.
- `rsp_ready` in 1: consumer takes data on `rsp_valid && rsp_ready`.
- `rsp_rdata` out `DATA_WIDTH`: read data, in request order.
- `init_done` out 1: controller open for requests.

## Operation
- **FSM states:** `INIT` and `RUN`.
  - `req_ready = (state==RUN) && (pending < 2)`.
  - `req_ready` never depends on `req_valid`, `req_we` or `rsp_ready` in the same cycle.
- **Accepted write:** drives the selected bank with `csb0=0`, `web0=0`, bank address and `din0` in the same cycle. No response is produced. All other banks get `csb0=1`.
- **Accepted read:**
  - Drives the selected bank with `csb0=0`, `web0=1`.
  - Registers the bank index and sets the `inflight` flag.
  - The next cycle, the macro `dout0` of the registered bank is the read result.
- **Response path:**
  - `rsp_valid = inflight || fifo_count != 0`.
  - `rsp_rdata` = FIFO head when the FIFO is non-empty, else the macro `dout0` (bypass).
  - If `inflight` and the result is not consumed this cycle (FIFO non-empty or `!rsp_ready`), the macro data is pushed into the FIFO at the edge.
- **`pending` counter:**
  - Holds reads accepted but not yet handshaken on the response channel (range 0..2).
  - +1 on read accept, −1 on response handshake; both in one cycle leaves it unchanged.
- **Ordering:** writes and reads are performed in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- **Boundaries:**
  - `pending==2` blocks both reads and writes.
  - The FIFO never overflows, because capacity (2) equals the `pending` limit.
  - Address wrap is not supported; every address is in range by construction.
- **Reset asserted mid-operation:**
  - All in-flight and buffered reads are dropped, with no response.
  - Macro contents are not guaranteed.
  - State goes to `INIT` (macro defined) or `RUN` after release.

## Timing
- **Reset values:**
  - `req_ready=0`, `rsp_valid=0`, `init_done=0`, `rsp_rdata=0` (FIFO cleared; bypass masked while `!inflight`).
  - All macro `csb0=1`.
- **Read latency:** accept at edge t, `rsp_valid=1` with data during cycle t+1 (1 cycle) when the FIFO is empty.
- **Throughput:** with `rsp_ready` held 1, one read or write accepted every cycle.
- **`rsp_ready` low:** after at most 2 outstanding reads, `req_ready` drops the cycle after the second read is accepted. It returns the cycle after the first response handshake.
- **Without the init macro:** `init_done` and `req_ready` rise at the first `clk0` edge after `rstb0` deasserts.

## Configuration
- **`SRAM_CTRL_INIT_EN` defined:**
  - After reset the FSM sits in `INIT`.
  - A `BANK_ADDR_WIDTH`-bit counter writes zero to all banks in parallel (`csb0=0`, `web0=0` on every bank), addresses 0 through `2**BANK_ADDR_WIDTH-1`.
  - `init_done` and the move to `RUN` happen at the edge after the last write: 512 cycles for the defaults.
  - `req_ready=0` throughout `INIT`.
- **Not defined:** no `INIT` state or counter, and contents are uninitialised.

## Structure
- **Package `sram_ctrl_pkg`:**
  - FSM state enum (`INIT`, `RUN`).
  - `RSP_DEPTH=2`.
  - Helper function computing `N_BANKS`.
- **Sub-module `sram_rsp_fifo`:** 2-entry, `DATA_WIDTH`-wide FIFO with push/pop/count.
- Macro instances are generated per bank inside the top.

## Test plan
- **Reset/init:** with the macro defined, release reset and read address 0x3FF → `init_done` rises after 512 cycles, and `rsp_rdata=0`.
- **Back-to-back, no stall:** `rsp_ready=1`, write 0xA5.. to address 0x001 then read 0x001 and 0x201 (bank 1) → data one cycle after each read, in order, with no `req_ready` bubbles.
- **Backpressure:** `rsp_ready=0` with 3 reads offered → exactly 2 accepted, then `req_ready=0`. Raise `rsp_ready` → both returned in order, then the third is accepted.
- **Simultaneous accept and pop:** `pending==2`, `rsp_ready=1` → a new read is accepted the cycle after the pop, and `pending` stays ≤2.
- **Mid-operation reset:** assert `rstb0` with 2 reads outstanding → `rsp_valid` drops immediately, and no stale response appears after release.
- **Bank isolation:** write distinct patterns to the same low address in every bank → each read returns its own bank's pattern.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared types and constants for the banked 1rw SRAM controller:
//   ctrl_state_e : controller FSM state (INIT sweep / RUN)
//   RSP_DEPTH    : response buffer depth, equal to the outstanding-read limit
//   n_banks_f    : number of macro banks for a given total/bank address width
package sram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    localparam int RSP_DEPTH = 2;

    function automatic int n_banks_f(input int addr_w, input int bank_addr_w);
        return 1 << (addr_w - bank_addr_w);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo
// Two-entry response buffer holding read data the consumer has not yet taken.
// Ports:
//   clk0, rstb0 : clock, asynchronous active-low reset (clears contents)
//   push, wdata : write wdata at the tail
//   pop         : drop the head entry (ignored when empty)
//   rdata       : head entry
//   count       : number of valid entries (0..2)
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 150
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  pop_ok_s;
    logic                  push_ok_s;

    // Pointer, storage and occupancy next-state; a push into a full buffer is
    // only legal when the head is leaving in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok_s  = pop && (count_q != 2'd0);
        push_ok_s = push && ((count_q != 2'(RSP_DEPTH)) || pop_ok_s);
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/sram_banked_1rw_ctrl.sv
// sram_banked_1rw_ctrl
// Valid/ready front end over N_BANKS 1rw SRAM macros with bank decoding, a
// 2-entry response buffer for consumer stalls, and an optional zero sweep.
// Optional feature macro: SRAM_CTRL_INIT_EN (zero all macros after reset).
// Ports:
//   clk0, rstb0          : clock (also clocks the macros), async active-low reset
//   req_valid/req_ready  : request handshake; req_we=1 write, 0 read
//   req_addr, req_wdata  : word address (upper bits = bank), write data
//   rsp_valid/rsp_ready  : read response handshake, rsp_rdata in request order
//   init_done            : controller open for requests
module sram_banked_1rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 150,
    parameter int BANK_ADDR_WIDTH = 9,
    parameter int ADDR_WIDTH      = 10
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done
);

    localparam int N_BANKS    = n_banks_f(ADDR_WIDTH, BANK_ADDR_WIDTH);
    localparam int BANK_SEL_W = (N_BANKS > 1) ? (ADDR_WIDTH - BANK_ADDR_WIDTH) : 1;

    logic                       run_s;
    logic                       init_active_s;
    logic [BANK_ADDR_WIDTH-1:0] init_addr_s;
    logic [BANK_SEL_W-1:0]      req_bank_s;
    logic                       req_fire_s;
    logic                       rd_fire_s;
    logic                       rsp_fire_s;
    logic                       fifo_push_s;
    logic                       fifo_pop_s;
    logic [1:0]                 fifo_count_s;
    logic [DATA_WIDTH-1:0]      fifo_head_s;
    logic [DATA_WIDTH-1:0]      macro_rdata_s;

    logic [1:0]                 pending_q, pending_d;
    logic                       inflight_q, inflight_d;
    logic [BANK_SEL_W-1:0]      rd_bank_q, rd_bank_d;

    logic [N_BANKS-1:0]         bank_csb_s;
    logic [N_BANKS-1:0]         bank_web_s;
    logic [BANK_ADDR_WIDTH-1:0] bank_addr_s;
    logic [DATA_WIDTH-1:0]      bank_din_s;
    logic [DATA_WIDTH-1:0]      bank_dout_s [N_BANKS];

    if (N_BANKS > 1) begin : g_bank_sel
        assign req_bank_s = req_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    end else begin : g_bank_single
        assign req_bank_s = 1'b0;
    end

`ifdef SRAM_CTRL_INIT_EN
    ctrl_state_e                state_q, state_d;
    logic [BANK_ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

    // Sweep FSM: walk every bank address once, then open for requests.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + BANK_ADDR_WIDTH'(1);
                if (&init_cnt_q) begin
                    state_d = RUN;
                end else begin
                    state_d = INIT;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Sweep FSM state and address counter.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign run_s         = (state_q == RUN);
    // Gated by rstb0 so the macros stay deselected while reset is held.
    assign init_active_s = (state_q == INIT) && rstb0;
    assign init_addr_s   = init_cnt_q;
`else
    logic open_q, open_d;

    // Controller opens at the first edge after reset release.
    always_comb begin
        open_d = 1'b1;
    end

    // Open flag register.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            open_q <= 1'b0;
        end else begin
            open_q <= open_d;
        end
    end

    assign run_s         = open_q;
    assign init_active_s = 1'b0;
    assign init_addr_s   = '0;
`endif

    // Ready depends only on registered state, never on this cycle's inputs.
    assign req_ready  = run_s && (pending_q < 2'(RSP_DEPTH));
    assign init_done  = run_s;
    assign req_fire_s = req_valid && req_ready;
    assign rd_fire_s  = req_fire_s && !req_we;

    assign macro_rdata_s = bank_dout_s[rd_bank_q];
    assign rsp_valid     = inflight_q || (fifo_count_s != 2'd0);
    assign rsp_fire_s    = rsp_valid && rsp_ready;
    // Buffer the macro result unless it goes straight to the consumer now.
    assign fifo_push_s   = inflight_q && ((fifo_count_s != 2'd0) || !rsp_ready);
    assign fifo_pop_s    = (fifo_count_s != 2'd0) && rsp_ready;

    // Response data: buffered head first; bypass is masked with no read in flight.
    always_comb begin
        rsp_rdata = '0;
        if (fifo_count_s != 2'd0) begin
            rsp_rdata = fifo_head_s;
        end else if (inflight_q) begin
            rsp_rdata = macro_rdata_s;
        end else begin
            rsp_rdata = '0;
        end
    end

    // Outstanding-read bookkeeping.
    always_comb begin
        pending_d  = pending_q;
        inflight_d = rd_fire_s;
        rd_bank_d  = rd_bank_q;
        case ({rd_fire_s, rsp_fire_s})
            2'b10:   pending_d = pending_q + 2'd1;
            2'b01:   pending_d = pending_q - 2'd1;
            default: pending_d = pending_q;
        endcase
        if (rd_fire_s) begin
            rd_bank_d = req_bank_s;
        end else begin
            rd_bank_d = rd_bank_q;
        end
    end

    // Outstanding-read registers; reset drops every in-flight read.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            pending_q  <= 2'd0;
            inflight_q <= 1'b0;
            rd_bank_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            rd_bank_q  <= rd_bank_d;
        end
    end

    // Macro port drive: sweep writes zero to every bank, else one selected bank.
    always_comb begin
        bank_csb_s  = '1;
        bank_web_s  = '1;
        bank_addr_s = req_addr[BANK_ADDR_WIDTH-1:0];
        bank_din_s  = req_wdata;
        if (init_active_s) begin
            bank_csb_s  = '0;
            bank_web_s  = '0;
            bank_addr_s = init_addr_s;
            bank_din_s  = '0;
        end else if (req_fire_s) begin
            bank_csb_s[req_bank_s] = 1'b0;
            bank_web_s[req_bank_s] = !req_we;
        end else begin
            bank_csb_s = '1;
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk0  (clk0),
        .rstb0 (rstb0),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (macro_rdata_s),
        .rdata (fifo_head_s),
        .count (fifo_count_s)
    );

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [2**BANK_ADDR_WIDTH];
        logic [DATA_WIDTH-1:0] dout_q;

        // 1rw macro array: write or registered read when selected, dout holds otherwise.
        always_ff @(posedge clk0) begin
            if (!bank_csb_s[b]) begin
                if (!bank_web_s[b]) begin
                    mem_q[bank_addr_s] <= bank_din_s;
                end else begin
                    dout_q <= mem_q[bank_addr_s];
                end
            end
        end

        assign bank_dout_s[b] = dout_q;
    end

endmodule

// File: tb/tb_sram_banked_1rw_ctrl.sv
// Scoreboard bench for sram_banked_1rw_ctrl: accepted reads push the expected
// word into a queue, a monitor pops and compares on every response handshake.
module tb_sram_banked_1rw_ctrl;

    localparam int DW  = 150;
    localparam int BAW = 9;
    localparam int AW  = 10;

    logic          clk0 = 1'b0;
    logic          rstb0;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        bit            timed;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk0 = ~clk0;

    always @(posedge clk0) cyc <= cyc + 1;

    sram_banked_1rw_ctrl #(
        .DATA_WIDTH      (DW),
        .BANK_ADDR_WIDTH (BAW),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk0      (clk0),
        .rstb0     (rstb0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    function automatic logic [DW-1:0] pat(input logic [7:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) r[i] = b[i % 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk0);
            if (rstb0 === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=%h required=none", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_rdata, e.data);
                    if (e.timed) chk("rsp_latency", DW'(cyc), DW'(e.due));
                end
            end
        end
    endtask

    // Present one request; aligned to #1 after a rising edge on entry and exit.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp, input bit timed, input bit no_wait);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk0);
            #1;
            n++;
        end
        if (no_wait) chk("no_bubble", DW'(n), DW'(0));
        if (!req_ready) begin
            chk("req_timeout", DW'(req_ready), DW'(1));
        end else begin
            if (!we) exp_q.push_back('{data: exp, due: cyc + 1, timed: timed});
            @(posedge clk0);
            #1;
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_we    = 1'b0;
        repeat (n) begin
            @(posedge clk0);
            #1;
        end
    endtask

    task automatic wait_init(input int exp_edges);
        int n;
        n = 0;
        while (!init_done && n < 700) begin
            @(posedge clk0);
            #1;
            n++;
        end
        chk("init_edges", DW'(n), DW'(exp_edges));
        chk("ready_after_init", DW'(req_ready), DW'(1));
    endtask

    initial begin
        int init_edges;
`ifdef SRAM_CTRL_INIT_EN
        init_edges = 512;
`else
        init_edges = 1;
`endif
        rstb0     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        fork
            run_monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk0);
        #1;
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        chk("rst_init_done", DW'(init_done), DW'(0));
        chk("rst_rsp_rdata", rsp_rdata, '0);
        rstb0 = 1'b1;
        wait_init(init_edges);

`ifdef SRAM_CTRL_INIT_EN
        issue(1'b0, 10'h3FF, '0, '0, 1'b1, 1'b1);
        idle(2);
`endif

        // Back-to-back, no stall
        rsp_ready = 1'b1;
        issue(1'b1, 10'h201, pat(8'h5A), '0, 1'b0, 1'b1);
        issue(1'b1, 10'h001, pat(8'hA5), '0, 1'b0, 1'b1);
        issue(1'b0, 10'h001, '0, pat(8'hA5), 1'b1, 1'b1);
        issue(1'b0, 10'h201, '0, pat(8'h5A), 1'b1, 1'b1);
        issue(1'b1, 10'h002, pat(8'h3C), '0, 1'b0, 1'b1);
        idle(3);

        // Backpressure: two reads accepted, third blocked
        rsp_ready = 1'b0;
        issue(1'b0, 10'h001, '0, pat(8'hA5), 1'b0, 1'b1);
        issue(1'b0, 10'h201, '0, pat(8'h5A), 1'b0, 1'b1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'h002;
        chk("bp_block0", DW'(req_ready), DW'(0));
        @(posedge clk0);
        #1;
        chk("bp_block1", DW'(req_ready), DW'(0));
        chk("bp_valid", DW'(rsp_valid), DW'(1));
        chk("bp_head", rsp_rdata, pat(8'hA5));
        rsp_ready = 1'b1;
        chk("bp_block2", DW'(req_ready), DW'(0));
        @(posedge clk0);
        #1;
        // Pop of the second response and accept of the third share this cycle
        chk("bp_resume", DW'(req_ready), DW'(1));
        exp_q.push_back('{data: pat(8'h3C), due: cyc + 1, timed: 1'b0});
        @(posedge clk0);
        #1;
        req_valid = 1'b0;
        chk("pop_accept_ready", DW'(req_ready), DW'(1));
        chk("pop_accept_valid", DW'(rsp_valid), DW'(1));
        idle(3);

        // Mid-operation reset with two reads outstanding
        rsp_ready = 1'b0;
        issue(1'b0, 10'h001, '0, pat(8'hA5), 1'b0, 1'b1);
        issue(1'b0, 10'h201, '0, pat(8'h5A), 1'b0, 1'b1);
        req_valid = 1'b0;
        chk("mid_valid_before", DW'(rsp_valid), DW'(1));
        rstb0 = 1'b0;
        #1;
        chk("mid_valid_drop", DW'(rsp_valid), DW'(0));
        chk("mid_ready_drop", DW'(req_ready), DW'(0));
        exp_q.delete();
        repeat (2) @(posedge clk0);
        #1;
        rstb0     = 1'b1;
        rsp_ready = 1'b1;
        wait_init(init_edges);
        for (int i = 0; i < 4; i++) begin
            chk("no_stale_rsp", DW'(rsp_valid), DW'(0));
            @(posedge clk0);
            #1;
        end

        // Bank isolation: same low address in each bank
        issue(1'b1, 10'h005, pat(8'h11), '0, 1'b0, 1'b1);
        issue(1'b1, 10'h205, pat(8'h22), '0, 1'b0, 1'b1);
        issue(1'b0, 10'h005, '0, pat(8'h11), 1'b1, 1'b1);
        issue(1'b0, 10'h205, '0, pat(8'h22), 1'b1, 1'b1);
        idle(4);

        chk("drained", DW'(exp_q.size()), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
